// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the sequenced ALU controller: ALU op codes, the
// immediate-select bit position and the controller state encoding.
package alu_seq_ctrl_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned ALUC_W      = 2;
    localparam int unsigned IMM_SEL_BIT = 2;

    typedef enum logic [ALUC_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl_regfile.sv
// Register file: 2**AW words, two operand read ports plus a debug port,
// one synchronous write port, r0 hardwired to zero.
module alu_regfile
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned AW = 3
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [AW-1:0]     x_addr,
    output logic [DATA_W-1:0] x_data,
    input  logic [AW-1:0]     y_addr,
    output logic [DATA_W-1:0] y_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned NREG = 2 ** AW;

    logic [DATA_W-1:0] regs [NREG];

    // Writes to r0 are dropped so the storage word itself also stays zero.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign x_data   = (x_addr   == '0) ? '0 : regs[x_addr];
    assign y_data   = (y_addr   == '0) ? '0 : regs[y_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-phase command sequencer (IDLE/READ/EXEC/WB) that feeds an external
// combinational ALU from a local register file and writes results back.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs,
    input  logic [REG_AW-1:0] cmd_rt,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [ALUC_W-1:0] alu_aluc,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_z,
    output logic              done,
    output logic [DATA_W-1:0] done_r,
    output logic              done_z,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e              state;
    logic [OP_W-1:0]     op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [REG_AW-1:0]   rs_q;
    logic [REG_AW-1:0]   rt_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   res_q;
    logic                res_z;
    logic [DATA_W-1:0]   src_x;
    logic [DATA_W-1:0]   src_y;
    logic                wr_en;

    assign wr_en = (state == ST_WB);

    alu_regfile #(
        .AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .clrn     (clrn),
        .x_addr   (rs_q),
        .x_data   (src_x),
        .y_addr   (rt_q),
        .y_data   (src_y),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (wr_en),
        .wr_addr  (rd_q),
        .wr_data  (res_q)
    );

    // cmd_ready is registered from the next state so it is high exactly in IDLE.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            res_z     <= 1'b0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_aluc  <= '0;
            done      <= 1'b0;
            done_r    <= '0;
            done_z    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        rd_q      <= cmd_rd;
                        rs_q      <= cmd_rs;
                        rt_q      <= cmd_rt;
                        imm_q     <= cmd_imm;
                        cmd_ready <= 1'b0;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_x    <= src_x;
                    alu_y    <= op_q[IMM_SEL_BIT] ? imm_q : src_y;
                    alu_aluc <= op_q[ALUC_W-1:0];
                    state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_r;
                    res_z <= alu_z;
                    state <= ST_WB;
                end
                ST_WB: begin
                    done      <= 1'b1;
                    done_r    <= res_q;
                    done_z    <= res_z;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU, a register-file
// reference model and a result scoreboard.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int unsigned AW   = 3;
    localparam int unsigned NREG = 2 ** AW;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic          clk;
    logic          clrn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [AW-1:0] cmd_rt;
    logic [31:0]   cmd_imm;
    logic [31:0]   alu_x;
    logic [31:0]   alu_y;
    logic [1:0]    alu_aluc;
    logic [31:0]   alu_r;
    logic          alu_z;
    logic          done;
    logic [31:0]   done_r;
    logic          done_z;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    int          n_checks;
    int          n_fail;
    logic [31:0] model [NREG];
    exp_t        sb [$];

    alu_seq_ctrl #(
        .REG_AW (AW)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs    (cmd_rs),
        .cmd_rt    (cmd_rt),
        .cmd_imm   (cmd_imm),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_aluc  (alu_aluc),
        .alu_r     (alu_r),
        .alu_z     (alu_z),
        .done      (done),
        .done_r    (done_r),
        .done_z    (done_z),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // External 32-bit add/sub/and/or ALU.
    always_comb begin
        case (alu_aluc)
            OP_ADD:  alu_r = alu_x + alu_y;
            OP_SUB:  alu_r = alu_x - alu_y;
            OP_AND:  alu_r = alu_x & alu_y;
            default: alu_r = alu_x | alu_y;
        endcase
        alu_z = (alu_r == 32'h0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
        case (op)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return x & y;
            default: return x | y;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NREG); i++) model[i] = 32'h0;
    endtask

    // Drive one command, expect done three edges after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [31:0] imm);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        exp_t        ent;
        int          w;
        int          lat;
        x = model[rs];
        y = op[2] ? imm : model[rt];
        r = ref_alu(op[1:0], x, y);
        sb.push_back({r, (r == 32'h0)});
        if (rd != '0) model[rd] = r;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_rd    = AW'($urandom);
        cmd_rs    = AW'($urandom);
        cmd_rt    = AW'($urandom);
        cmd_imm   = $urandom;
        check("ready_low_after_accept", 32'(cmd_ready), 32'd0);
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_latency", 32'(lat), 32'd3);
        ent = sb.pop_front();
        if (done) begin
            check("done_r", done_r, ent.r);
            check("done_z", 32'(done_z), 32'(ent.z));
            check("alu_aluc_hold", 32'(alu_aluc), 32'(op[1:0]));
            dbg_addr = rd;
            #1;
            check("dbg_writeback", dbg_data, (rd == '0) ? 32'h0 : r);
            @(posedge clk);
            #1;
            check("done_single_pulse", 32'(done), 32'd0);
        end
    endtask

    initial begin
        exp_t ent;
        int   accepts;
        int   done_cnt;
        n_checks  = 0;
        n_fail    = 0;
        clrn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs    = '0;
        cmd_rt    = '0;
        cmd_imm   = '0;
        dbg_addr  = '0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_r", done_r, 32'h0);
        check("rst_done_z", 32'(done_z), 32'd0);
        check("rst_alu_x", alu_x, 32'h0);
        check("rst_alu_y", alu_y, 32'h0);
        check("rst_alu_aluc", 32'(alu_aluc), 32'd0);
        dbg_addr = AW'(1);
        #1;
        check("rst_reg1", dbg_data, 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Immediate load, subtract to zero, subtract wrap-around
        issue(3'b100, AW'(1), AW'(0), AW'(0), 32'd5);
        issue(3'b101, AW'(2), AW'(1), AW'(0), 32'd5);
        issue(3'b101, AW'(3), AW'(0), AW'(0), 32'd1);

        // Register-register and/or
        issue(3'b100, AW'(1), AW'(0), AW'(0), 32'hF0F0_F0F0);
        issue(3'b100, AW'(2), AW'(0), AW'(0), 32'h0FF0_0FF0);
        issue(3'b010, AW'(3), AW'(1), AW'(2), 32'hDEAD_BEEF);
        issue(3'b011, AW'(4), AW'(1), AW'(2), 32'h1234_5678);

        // Destination aliases both sources
        issue(3'b000, AW'(1), AW'(1), AW'(1), 32'h0);

        // cmd_valid held high: one accept every four cycles
        cmd_op    = 3'b100;
        cmd_rd    = AW'(5);
        cmd_rs    = AW'(5);
        cmd_rt    = AW'(0);
        cmd_imm   = 32'd1;
        cmd_valid = 1'b1;
        accepts   = 0;
        for (int e = 0; e < 16; e++) begin
            @(negedge clk);
            check("ready_pattern", 32'(cmd_ready), 32'((e % 4) == 0));
            if (cmd_ready) begin
                model[5] = model[5] + 32'd1;
                sb.push_back({model[5], (model[5] == 32'h0)});
                accepts++;
            end
            @(posedge clk);
            #1;
            if (done) begin
                check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    ent = sb.pop_front();
                    check("stream_done_r", done_r, ent.r);
                end
            end
        end
        cmd_valid = 1'b0;
        check("stream_accepts", 32'(accepts), 32'd4);
        check("stream_drained", 32'(sb.size()), 32'd0);
        sb.delete();

        // Write to r0 discarded but done still pulses
        issue(3'b100, AW'(0), AW'(0), AW'(0), 32'd7);
        dbg_addr = AW'(0);
        #1;
        check("r0_stays_zero", dbg_data, 32'h0);

        // Reset during EXEC aborts the command
        @(negedge clk);
        cmd_op    = 3'b000;
        cmd_rd    = AW'(6);
        cmd_rs    = AW'(1);
        cmd_rt    = AW'(1);
        cmd_imm   = 32'h0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("exec_alu_x", alu_x, model[1]);
        clrn = 1'b0;
        #1;
        check("abort_alu_x", alu_x, 32'h0);
        check("abort_done", 32'(done), 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        done_cnt = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_alu_x_after", alu_x, 32'h0);
        dbg_addr = AW'(6);
        #1;
        check("abort_rd_zero", dbg_data, 32'h0);
        dbg_addr = AW'(1);
        #1;
        check("abort_reg1_cleared", dbg_data, 32'h0);

        // Recovery after abort
        issue(3'b100, AW'(6), AW'(0), AW'(0), 32'd123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: REG_AW, default 3, register-file address width (2**REG_AW registers of 32 bits).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 clrn  in  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  controller can accept a command (high only in IDLE).
REQ-006 cmd_op  in  3  [1:0] ALU op (00 add, 01 sub, 10 and, 11 or); [2] 1 = Y operand from cmd_imm, 0 = from register rt.
REQ-007 cmd_rd / cmd_rs / cmd_rt  in  REG_AW each  destination / X source / Y source register.
REQ-008 cmd_imm  in  32  immediate Y operand.
REQ-009 alu_x, alu_y  out  32  registered operands driven to the external combinational ALU.
REQ-010 alu_aluc  out  2  registered ALU op code, same encoding as cmd_op[1:0].
REQ-011 alu_r  in  32  ALU result; alu_z  in  1  ALU zero flag.
REQ-012 done  out  1  one-cycle pulse when a result is written back.
REQ-013 done_r  out  32  result of last completed command; done_z  out  1  its zero flag.
REQ-014 dbg_addr  in  REG_AW, dbg_data  out  32  combinational register-file read port.

Function
REQ-015 FSM states IDLE, READ, EXEC, WB; IDLE->READ on cmd_valid&&cmd_ready; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-016 In the accepting cycle the controller latches cmd_op, cmd_rd, cmd_rs, cmd_rt and cmd_imm; the inputs are don't-care afterwards.
REQ-017 READ: alu_x <= reg[rs]; alu_y <= op[2] ? imm : reg[rt]; alu_aluc <= op[1:0].
REQ-018 EXEC: capture alu_r and alu_z into internal result registers.
REQ-019 WB: reg[rd] <= captured result unless rd==0; done_r/done_z updated; done high for exactly this cycle.
REQ-020 Latency: a command accepted at edge k produces done high in the cycle after edge k+3; throughput is one command per 4 cycles.
REQ-021 cmd_ready is low in READ, EXEC and WB; cmd_valid in those states is ignored (no queuing).
REQ-022 Register 0 always reads 0 on every read path; writes to it are discarded, but done still pulses.
REQ-023 rd equal to rs or rt is legal; sources are read in READ, before the WB write.
REQ-024 Arithmetic is 32-bit modulo 2**32; carry and overflow are not reported.
REQ-025 alu_x, alu_y and alu_aluc hold their values outside READ.
REQ-026 dbg_data reflects a WB write from the cycle after the write edge.

Reset
REQ-027 While clrn is low: FSM = IDLE; all registers = 0; alu_x = alu_y = 0; alu_aluc = 00; done = 0; done_r = 0; done_z = 0.
REQ-028 cmd_ready = 1 from the first cycle after clrn deasserts.
REQ-029 Reset during READ, EXEC or WB aborts the command: no write-back and no done pulse.

Structure
REQ-030 The shared package holds the op encodings (ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11), the immediate-select bit index, and the FSM state encoding.
REQ-031 One sub-module, alu_regfile: 2**REG_AW x 32 storage with two combinational read ports, the debug read port, one synchronous write port, the r0 hardwired to zero, and async active-low clear.
REQ-032 The ALU is external to this block; the bench connects the existing 32-bit add/sub/and/or ALU between alu_x/alu_y/alu_aluc and alu_r/alu_z.

Verification
REQ-033 Reset, then cmd(op=100, rd=1, rs=0, imm=5) -> done 4 cycles after accept; done_r=5; done_z=0; reg1=5.
REQ-034 reg1=5; cmd(op=101, rd=2, rs=1, imm=5) -> done_r=0, done_z=1; then cmd(op=101, rd=3, rs=0, imm=1) -> done_r=32'hFFFFFFFF.
REQ-035 reg1=32'hF0F0F0F0, reg2=32'h0FF00FF0: and (op=010) -> 32'h00F000F0; or (op=011) -> 32'hFFF0FFF0.
REQ-036 cmd_valid held high continuously -> exactly one accept per 4 cycles; cmd_ready low for 3 cycles after each accept.
REQ-037 cmd with rd=0, imm=7 -> done pulses, done_r=7, dbg_data at addr 0 stays 0.
REQ-038 clrn pulsed low during EXEC -> no done pulse; target register stays 0; alu_x=0; cmd_ready=1 after release.
